// File: rtl/led_status_driver.sv
// led_status_driver
// Front-panel status LEDs for the RefLock II CPLD. LED1 shows that the
// reference is present. LED2 shows the lock state: off, slow blink, solid or
// fast blink. lamp_test lights both LEDs without disturbing the state machine.

module led_status_driver #(
  parameter int TICK_DIV         = 10000,
  parameter int QUAL_TICKS       = 1000,
  parameter int FAULT_HOLD_TICKS = 3000,
  parameter int SLOW_HALF_TICKS  = 500,
  parameter int FAST_HALF_TICKS  = 100
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ref_in,
  input  logic       lock_in,
  input  logic       lamp_test,
  output logic       LED1,
  output logic       LED2,
  output logic       locked,
  output logic [1:0] state
);

  localparam int PRESC_W = $clog2(TICK_DIV) + 1;
  localparam int QUAL_W  = $clog2(QUAL_TICKS) + 1;
  localparam int HOLD_W  = $clog2(FAULT_HOLD_TICKS) + 1;
  localparam int SLOW_W  = $clog2(SLOW_HALF_TICKS) + 1;
  localparam int FAST_W  = $clog2(FAST_HALF_TICKS) + 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [QUAL_W-1:0]  QUAL_LAST  = QUAL_W'(QUAL_TICKS);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(FAULT_HOLD_TICKS);
  localparam logic [SLOW_W-1:0]  SLOW_LAST  = SLOW_W'(SLOW_HALF_TICKS - 1);
  localparam logic [FAST_W-1:0]  FAST_LAST  = FAST_W'(FAST_HALF_TICKS - 1);

  localparam logic [1:0] ST_NO_REF  = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;
  localparam logic [1:0] ST_FAULT   = 2'd3;

  logic [1:0]         r_ref_sync;
  logic [1:0]         r_lock_sync;
  logic [1:0]         r_lt_sync;
  logic [PRESC_W-1:0] r_presc;
  logic [SLOW_W-1:0]  r_slow_cnt;
  logic [FAST_W-1:0]  r_fast_cnt;
  logic               r_slow_ph;
  logic               r_fast_ph;
  logic [1:0]         r_state;
  logic [QUAL_W-1:0]  r_qual;
  logic [HOLD_W-1:0]  r_hold;

  logic               w_ref_s;
  logic               w_lock_s;
  logic               w_lt_s;
  logic               w_tick;
  logic [1:0]         w_state_nxt;
  logic [QUAL_W-1:0]  w_qual_nxt;
  logic [HOLD_W-1:0]  w_hold_nxt;
  logic [QUAL_W-1:0]  w_qual_inc;
  logic [HOLD_W-1:0]  w_hold_inc;
  logic               w_led2_pat;

  assign w_ref_s    = r_ref_sync[1];
  assign w_lock_s   = r_lock_sync[1];
  assign w_lt_s     = r_lt_sync[1];
  assign w_tick     = (r_presc == PRESC_LAST);
  assign w_qual_inc = r_qual + QUAL_W'(1);
  assign w_hold_inc = r_hold + HOLD_W'(1);
  assign state      = r_state;

  // Two-flop synchronisers for the three asynchronous inputs.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, exactly like hardware.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ref_sync  <= '0;
      r_lock_sync <= '0;
      r_lt_sync   <= '0;
    end else begin
      r_ref_sync  <= {r_ref_sync[0], ref_in};
      r_lock_sync <= {r_lock_sync[0], lock_in};
      r_lt_sync   <= {r_lt_sync[0], lamp_test};
    end
  end

  // Prescaler producing the 1 ms tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PRESC_W'(1);
    end
  end

  // Free-running slow and fast blink phases, each toggled after its half-period.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_slow_cnt <= '0;
      r_fast_cnt <= '0;
      r_slow_ph  <= 1'b0;
      r_fast_ph  <= 1'b0;
    end else if (w_tick) begin
      if (r_slow_cnt == SLOW_LAST) begin
        r_slow_cnt <= '0;
        r_slow_ph  <= ~r_slow_ph;
      end else begin
        r_slow_cnt <= r_slow_cnt + SLOW_W'(1);
      end
      if (r_fast_cnt == FAST_LAST) begin
        r_fast_cnt <= '0;
        r_fast_ph  <= ~r_fast_ph;
      end else begin
        r_fast_cnt <= r_fast_cnt + FAST_W'(1);
      end
    end
  end

  // Next-state and counter logic for the lock state machine.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_qual_nxt  = r_qual;
    w_hold_nxt  = r_hold;
    case (r_state)
      ST_NO_REF: begin
        w_qual_nxt = '0;
        w_hold_nxt = '0;
        if (w_ref_s) begin
          w_state_nxt = ST_ACQUIRE;
        end
      end
      ST_ACQUIRE: begin
        // Losing the reference wins over any qualification progress.
        if (!w_ref_s) begin
          w_state_nxt = ST_NO_REF;
          w_qual_nxt  = '0;
        end else if (!w_lock_s) begin
          w_qual_nxt = '0;
        end else if (w_tick) begin
          if (w_qual_inc == QUAL_LAST) begin
            w_state_nxt = ST_LOCKED;
            w_qual_nxt  = '0;
          end else begin
            w_qual_nxt = w_qual_inc;
          end
        end
      end
      ST_LOCKED: begin
        if (!w_lock_s || !w_ref_s) begin
          w_state_nxt = ST_FAULT;
          w_hold_nxt  = '0;
        end
      end
      default: begin
        // FAULT: inputs are ignored until the hold time has elapsed.
        if (w_tick) begin
          if (w_hold_inc == HOLD_LAST) begin
            w_state_nxt = w_ref_s ? ST_ACQUIRE : ST_NO_REF;
            w_hold_nxt  = '0;
            w_qual_nxt  = '0;
          end else begin
            w_hold_nxt = w_hold_inc;
          end
        end
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_NO_REF;
      r_qual  <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_qual  <= w_qual_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // LED2 pattern selected by the current state.
  always_comb begin
    w_led2_pat = 1'b0;
    case (r_state)
      ST_ACQUIRE: w_led2_pat = r_slow_ph;
      ST_LOCKED:  w_led2_pat = 1'b1;
      ST_FAULT:   w_led2_pat = r_fast_ph;
      default:    w_led2_pat = 1'b0;
    endcase
  end

  // Registered output drive; lamp test overrides only the LEDs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      LED1   <= 1'b0;
      LED2   <= 1'b0;
      locked <= 1'b0;
    end else begin
      LED1   <= w_lt_s | w_ref_s;
      LED2   <= w_lt_s | w_led2_pat;
      locked <= (r_state == ST_LOCKED);
    end
  end

endmodule
